// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for three requesters, with a register busy scoreboard.
// One-cycle write latency; one accepted transfer per cycle, and Gnt only ever selects an active Req.
module regfile_wb_arbiter #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREQ = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      Req,
    input  logic [NREQ*AW-1:0]   ReqRD,
    input  logic [NREQ*DW-1:0]   ReqData,
    output logic [NREQ-1:0]      Gnt,
    input  logic                 Issue,
    input  logic [AW-1:0]        IssueRD,
    input  logic [AW-1:0]        RS1,
    input  logic [AW-1:0]        RS2,
    output logic                 Stall,
    output logic                 RegWrite,
    output logic [AW-1:0]        RD,
    output logic [DW-1:0]        WData,
    output logic [AW:0]          PendCnt
);

    localparam int PW   = $clog2(NREQ);
    localparam int NREG = 1 << AW;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel;
    logic            found;
    logic            accept;
    logic [AW-1:0]   sel_rd;
    logic [DW-1:0]   sel_data;
    logic            wr_q;
    logic [AW-1:0]   rd_q;
    logic [DW-1:0]   wdata_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     pend_q;
    logic [AW:0]     pend_d;

    // First requester at or after ptr, scanning modulo NREQ.
    always_comb begin
        int idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && Req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    always_comb begin
        Gnt = '0;
        if (found && !Reset) begin
            Gnt[sel] = 1'b1;
        end
    end

    assign accept   = |Gnt;
    assign sel_rd   = ReqRD[sel*AW +: AW];
    assign sel_data = ReqData[sel*DW +: DW];

    // Set is applied after clear so a same-cycle re-issue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (Issue && (IssueRD != '0)) begin
            busy_d[IssueRD] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_d = pend_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr     <= '0;
            wr_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
            pend_q  <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            wr_q   <= accept && (sel_rd != '0);
            if (accept) begin
                ptr <= (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
            end
            // RD/WData track the last real register-file write; writes to x0 are dropped.
            if (accept && (sel_rd != '0)) begin
                rd_q    <= sel_rd;
                wdata_q <= sel_data;
            end
        end
    end

    assign Stall = busy_q[RS1] | busy_q[RS2];

    // A reset arriving right after an acceptance must suppress the pending write at once.
    assign RegWrite = wr_q & ~Reset;
    assign RD       = Reset ? '0 : rd_q;
    assign WData    = Reset ? '0 : wdata_q;
    assign PendCnt  = Reset ? '0 : pend_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: DW, 32, writeback data width; AW, 5, register address width; NREQ, 3, number of writeback requesters (fixed at 3).
REQ-002 Clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-004 Req  in  3  per-requester writeback request; bit i is requester i.
REQ-005 ReqRD  in  15  destination register per requester; bits [5i+4:5i] belong to requester i.
REQ-006 ReqData  in  96  write data per requester; bits [32i+31:32i] belong to requester i.
REQ-007 Gnt  out  3  combinational one-hot grant; Req[i]&Gnt[i] is an accepted transfer.
REQ-008 Issue  in  1  an instruction with destination IssueRD is dispatched this cycle.
REQ-009 IssueRD  in  5  destination register of the dispatched instruction.
REQ-010 RS1, RS2  in  5 each  source registers of the instruction being decoded.
REQ-011 Stall  out  1  combinational hazard flag, 1 when RS1 or RS2 has a pending write.
REQ-012 RegWrite  out  1  registered write enable to the register file.
REQ-013 RD  out  5  registered register-file write address.
REQ-014 WData  out  32  registered register-file write data.
REQ-015 PendCnt  out  6  registered count of busy registers (0..31).

Function
REQ-016 Arbitration SHALL be round-robin over Req with rotating pointer Ptr (0..2); the first requester at or after Ptr (mod 3) with Req=1 gets Gnt; Gnt=0 when Req=0.
REQ-017 At most one Gnt bit SHALL be high per cycle; Gnt SHALL depend only on Req and Ptr, never on ReqRD/ReqData.
REQ-018 On an accepted transfer from requester i, Ptr SHALL become (i+1) mod 3 next cycle; with no acceptance Ptr SHALL hold.
REQ-019 Write latency SHALL be exactly 1 cycle: a transfer accepted in cycle N drives RegWrite=1, RD=ReqRD[i], WData=ReqData[i] in cycle N+1 only.
REQ-020 RegWrite SHALL be 0 in any cycle following a cycle with no acceptance; RD and WData SHALL hold their last values.
REQ-021 An accepted transfer with ReqRD[i]=0 SHALL be consumed (Gnt, Ptr update) but SHALL produce RegWrite=0 in N+1 and SHALL not alter the scoreboard.
REQ-022 Scoreboard: 32 busy bits; Issue=1 with IssueRD!=0 sets Busy[IssueRD] next cycle; IssueRD=0 is ignored; Busy[0] SHALL always read 0.
REQ-023 Busy[RD] SHALL clear on the cycle after RegWrite=1 is driven for that RD (i.e. clear takes effect at end of the RegWrite cycle).
REQ-024 If set (Issue) and clear (RegWrite) target the same register in the same cycle, set SHALL win and Busy stays 1.
REQ-025 Clear of a register not currently busy SHALL be harmless (Busy stays 0).
REQ-026 Stall SHALL equal Busy[RS1] | Busy[RS2] from current registered state; RS=0 never stalls; no bypass from in-flight RegWrite.
REQ-027 PendCnt SHALL equal the population count of Busy, updated in the same cycle as Busy.
REQ-028 Back-to-back acceptances every cycle SHALL be supported with no bubbles; throughput 1 write/cycle.

Reset
REQ-029 While Reset=1: Ptr=0, Busy all 0, PendCnt=0, RegWrite=0, RD=0, WData=0.
REQ-030 Gnt SHALL be forced to 0 while Reset=1; no transfer is accepted during reset.
REQ-031 Reset asserted in the cycle after an acceptance SHALL discard that write: RegWrite stays 0.

Verification
REQ-032 Reset, then Req=3'b111 for 3 cycles with distinct RDs 1,2,3 -> Gnt 001,010,100; RegWrite writes RD 1,2,3 in the following cycles.
REQ-033 Issue RD=5, next cycle RS1=5 -> Stall=1, PendCnt=1; requester 1 writes RD=5, WData=0xDEADBEEF -> RegWrite with those values, Stall=0 one cycle later, PendCnt=0.
REQ-034 Issue RD=7 in the same cycle RegWrite drives RD=7 -> Busy[7] remains 1, Stall=1 for RS2=7.
REQ-035 Requester 2 writes RD=0 -> Gnt[2]=1, Ptr advances to 0, RegWrite=0 next cycle, PendCnt unchanged.
REQ-036 Accept write RD=9 then assert Reset next cycle -> RegWrite=0, RD=0, WData=0, PendCnt=0, next Gnt goes to requester 0.
